// File: rtl/mux_2_6_arbiter.sv
// Round-robin arbiter that drives the select of a 2:1 6-bit bus mux, with a hold counter bounding tenure.
// Optional MUX_ARB_LOCK_EN adds CC_ARB_lock_In, which suppresses forced handover while asserted.
module mux_2_6_arbiter #(
  parameter int DATAWIDTH_MUX_SELECTION = 1,
  parameter int HOLD_WIDTH              = 4,
  parameter int MAX_HOLD                = 8
) (
  input  logic                               CC_ARB_CLOCK_50,
  input  logic                               CC_ARB_RESET_InHigh,
  input  logic                               CC_ARB_request0_In,
  input  logic                               CC_ARB_request1_In,
`ifdef MUX_ARB_LOCK_EN
  input  logic                               CC_ARB_lock_In,
`endif
  output logic                               CC_ARB_grant0_Out,
  output logic                               CC_ARB_grant1_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] CC_ARB_selection_OutBUS,
  output logic                               CC_ARB_busy_Out
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);

  state_t                state, state_nxt;
  logic [HOLD_WIDTH-1:0] cnt, cnt_nxt;
  logic                  last, last_nxt;   // last-served requester; 1 lets requester 0 win the first tie
  logic                  lock;
  logic                  own, other;

`ifdef MUX_ARB_LOCK_EN
  assign lock = CC_ARB_lock_In;
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge CC_ARB_CLOCK_50) begin
    if (CC_ARB_RESET_InHigh) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Own/other requests relative to the current owner let both GNT states share one rule set.
  always_comb begin
    own   = (state == GNT1) ? CC_ARB_request1_In : CC_ARB_request0_In;
    other = (state == GNT1) ? CC_ARB_request0_In : CC_ARB_request1_In;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (CC_ARB_request0_In && (!CC_ARB_request1_In || last)) begin
          state_nxt = GNT0;
          cnt_nxt   = '0;
          last_nxt  = 1'b0;
        end else if (CC_ARB_request1_In) begin
          state_nxt = GNT1;
          cnt_nxt   = '0;
          last_nxt  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!own && !other) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!own || (other && !lock && cnt == HOLD_LAST)) begin
          state_nxt = (state == GNT0) ? GNT1 : GNT0;
          cnt_nxt   = '0;
          last_nxt  = (state == GNT0);
        end else if (!lock && cnt != HOLD_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    CC_ARB_grant0_Out       = (state == GNT0);
    CC_ARB_grant1_Out       = (state == GNT1);
    CC_ARB_selection_OutBUS = DATAWIDTH_MUX_SELECTION'(state == GNT1);
    CC_ARB_busy_Out         = (state == GNT0) || (state == GNT1);
  end

endmodule

// File: tb/tb_mux_2_6_arbiter.sv
// Directed bench for mux_2_6_arbiter: vector table plus round-robin, MAX_HOLD=1 and lock sequences.
module tb_mux_2_6_arbiter;

  logic clk = 1'b0;
  logic rst, r0, r1, r0b, r1b, lock;
  logic g0, g1, busy, g0b, g1b, busyb;
  logic [0:0] sel, selb;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_2_6_arbiter dut_a (
    .CC_ARB_CLOCK_50(clk), .CC_ARB_RESET_InHigh(rst),
    .CC_ARB_request0_In(r0), .CC_ARB_request1_In(r1),
`ifdef MUX_ARB_LOCK_EN
    .CC_ARB_lock_In(lock),
`endif
    .CC_ARB_grant0_Out(g0), .CC_ARB_grant1_Out(g1),
    .CC_ARB_selection_OutBUS(sel), .CC_ARB_busy_Out(busy)
  );

  mux_2_6_arbiter #(.MAX_HOLD(1)) dut_b (
    .CC_ARB_CLOCK_50(clk), .CC_ARB_RESET_InHigh(rst),
    .CC_ARB_request0_In(r0b), .CC_ARB_request1_In(r1b),
`ifdef MUX_ARB_LOCK_EN
    .CC_ARB_lock_In(lock),
`endif
    .CC_ARB_grant0_Out(g0b), .CC_ARB_grant1_Out(g1b),
    .CC_ARB_selection_OutBUS(selb), .CC_ARB_busy_Out(busyb)
  );

  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [3:0] exp;   // {grant0, grant1, selection, busy}
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got g0g1/sel/busy=%b expected %b", name, idx, act, exp);
    end
  endtask

  // Grants must never overlap on either instance.
  always @(negedge clk) begin
    if ((g0 && g1) || (g0b && g1b)) begin
      failures++;
      $display("FAIL mutex a=%b%b b=%b%b expected at most one grant", g0, g1, g0b, g1b);
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'b0000};  // reset with both requesting
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'b1001};  // first grant to requester 0
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b0111};  // direct handover, no idle bubble
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'b0111};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'b0111};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'b1001};  // tie, last served 1 -> requester 0
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b1001};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4'b0111};  // tie, last served 0 -> requester 1
    vecs[12] = '{1'b1, 1'b1, 1'b1, 4'b0000};  // reset mid-grant
    vecs[13] = '{1'b0, 1'b1, 1'b1, 4'b1001};  // pointer back to reset value
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'b0000};

    rst = 1'b1; r0 = 1'b0; r1 = 1'b0; r0b = 1'b0; r1b = 1'b0; lock = 1'b0;

    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst; r0 = vecs[i].r0; r1 = vecs[i].r1;
      tick();
      chk("vec", i, {g0, g1, sel, busy}, vecs[i].exp);
    end

    // Both requesting, last served 0: eight cycles each, starting with requester 1.
    r0 = 1'b1; r1 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (((k / 8) % 2) == 0) chk("rr", k, {g0, g1, sel, busy}, 4'b0111);
      else                    chk("rr", k, {g0, g1, sel, busy}, 4'b1001);
    end
    r0 = 1'b0; r1 = 1'b0;
    tick();
    chk("rr_idle", 0, {g0, g1, sel, busy}, 4'b0000);

    // Counter saturates while uncontested; a late competitor then takes over at once.
    r0 = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("sat_hold", 0, {g0, g1, sel, busy}, 4'b1001);
    r1 = 1'b1;
    tick();
    chk("sat_handover", 0, {g0, g1, sel, busy}, 4'b0111);
    r0 = 1'b0; r1 = 1'b0;
    tick();
    chk("sat_idle", 0, {g0, g1, sel, busy}, 4'b0000);

    // MAX_HOLD=1 alternates every cycle.
    r0b = 1'b1; r1b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if ((k % 2) == 0) chk("mh1", k, {g0b, g1b, selb, busyb}, 4'b1001);
      else              chk("mh1", k, {g0b, g1b, selb, busyb}, 4'b0111);
    end
    r0b = 1'b0; r1b = 1'b0;
    tick();
    chk("mh1_idle", 0, {g0b, g1b, selb, busyb}, 4'b0000);

`ifdef MUX_ARB_LOCK_EN
    // Reach counter 7 uncontested, then lock through 20 contested cycles.
    r0 = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    lock = 1'b1; r1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("lock", k, {g0, g1, sel, busy}, 4'b1001);
    end
    lock = 1'b0;
    tick();
    chk("unlock", 0, {g0, g1, sel, busy}, 4'b0111);
    r0 = 1'b0; r1 = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
